// File: rtl/axi4lite_amm_bridge_if.sv
// Avalon-MM bus bundle used between the AXI4-Lite bridge and its memory-mapped slave.
// Zero read latency: readdata is valid whenever read=1 and waitrequest=0.
interface amm_if #(
  parameter int P_ASIZE  = 32,
  parameter int P_DBYTES = 4
);
  logic [P_ASIZE-1:0]    address;
  logic [P_DBYTES*8-1:0] writedata;
  logic [P_DBYTES*8-1:0] readdata;
  logic [P_DBYTES-1:0]   byteenable;
  logic                  write;
  logic                  read;
  logic                  waitrequest;

  modport master (
    output address, writedata, byteenable, write, read,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, writedata, byteenable, write, read,
    output waitrequest, readdata
  );
endinterface

// File: rtl/axi4lite_amm_bridge.sv
// AXI4-Lite slave to Avalon-MM master bridge, one transaction in flight,
// round-robin between writes and reads, optional waitrequest timeout (SLVERR).
module axi4lite_amm_bridge #(
  parameter int P_ASIZE   = 32,
  parameter int P_DBYTES  = 4,
  parameter int P_TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [P_ASIZE-1:0]    awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [P_DBYTES*8-1:0] wdata,
  input  logic [P_DBYTES-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [P_ASIZE-1:0]    araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [P_DBYTES*8-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  amm_if.master                 amm,
  output logic [2:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload stay stable until then, and ready never waits on anything but valid.

  typedef enum logic [2:0] {IDLE, WR, RD, BRSP, RRSP} state_t;

  localparam int DW = P_DBYTES * 8;
  localparam int TW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]      TMO_LAST  = (P_TIMEOUT > 0) ? TW'(P_TIMEOUT - 1) : '0;
  localparam logic [P_ASIZE-1:0] ADDR_MASK = ~P_ASIZE'(P_DBYTES - 1);
  localparam logic [1:0]         RESP_OKAY   = 2'b00;
  localparam logic [1:0]         RESP_SLVERR = 2'b10;

  state_t                state, state_nxt;
  logic                  wr_prio;
  logic [P_ASIZE-1:0]    addr_q;
  logic [DW-1:0]         wdata_q;
  logic [P_DBYTES-1:0]   be_q;
  logic [TW-1:0]         tcnt;

  logic wr_pend, grant_wr, grant_rd;
  logic amm_busy, amm_done, tmo_hit;

  assign wr_pend  = awvalid & wvalid;
  assign amm_busy = (state == WR) | (state == RD);
  assign amm_done = amm_busy & ~amm.waitrequest;
  // Fires on the last tolerated wait cycle, so the command drops on the next edge.
  assign tmo_hit  = (P_TIMEOUT != 0) && amm_busy && amm.waitrequest && (tcnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && wr_pend && (wr_prio || !arvalid)) begin
          grant_wr  = 1'b1;
          state_nxt = WR;
        end else if (rst_n && arvalid) begin
          grant_rd  = 1'b1;
          state_nxt = RD;
        end
      end
      WR:      if (amm_done || tmo_hit) state_nxt = BRSP;
      RD:      if (amm_done || tmo_hit) state_nxt = RRSP;
      BRSP:    if (bready) state_nxt = IDLE;
      RRSP:    if (rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_prio <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      tcnt    <= '0;
      bresp   <= RESP_OKAY;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_wr) begin
        addr_q  <= awaddr;
        wdata_q <= wdata;
        be_q    <= wstrb;
        wr_prio <= 1'b0;
        tcnt    <= '0;
      end else if (grant_rd) begin
        addr_q  <= araddr;
        be_q    <= '1;
        wr_prio <= 1'b1;
        tcnt    <= '0;
      end else if ((P_TIMEOUT != 0) && amm_busy && amm.waitrequest) begin
        tcnt <= tcnt + TW'(1);
      end
      if (state == WR && amm_done) bresp <= RESP_OKAY;
      if (state == WR && tmo_hit)  bresp <= RESP_SLVERR;
      if (state == RD && amm_done) begin
        rdata <= amm.readdata;
        rresp <= RESP_OKAY;
      end
      if (state == RD && tmo_hit) begin
        rdata <= '0;
        rresp <= RESP_SLVERR;
      end
    end
  end

  assign awready = grant_wr;
  assign wready  = grant_wr;
  assign arready = grant_rd;
  assign bvalid  = (state == BRSP);
  assign rvalid  = (state == RRSP);

  assign amm.write      = (state == WR);
  assign amm.read       = (state == RD);
  assign amm.address    = addr_q & ADDR_MASK;
  assign amm.writedata  = wdata_q;
  assign amm.byteenable = be_q;

  assign dbg_state = state;

endmodule

// File: doc/axi4lite_amm_bridge.md
AXI4LITE_AMM_BRIDGE -- requirements
Module: axi4lite_amm_bridge

Interface
REQ-001 SHALL have parameter P_ASIZE, default 32: AXI/AMM byte-address width.
REQ-002 SHALL have parameter P_DBYTES, default 4: data-bus width in bytes (power of 2).
REQ-003 SHALL have parameter P_TIMEOUT, default 256: max waitrequest-high cycles per AMM access; 0 disables the timeout.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports awaddr/awvalid/awready  in/in/out  P_ASIZE/1/1  AXI4-Lite write-address channel.
REQ-007 SHALL have ports wdata/wstrb/wvalid/wready  in/in/in/out  P_DBYTES*8/P_DBYTES/1/1  AXI4-Lite write-data channel.
REQ-008 SHALL have ports bresp/bvalid/bready  out/out/in  2/1/1  AXI4-Lite write-response channel.
REQ-009 SHALL have ports araddr/arvalid/arready  in/in/out  P_ASIZE/1/1  AXI4-Lite read-address channel.
REQ-010 SHALL have ports rdata/rresp/rvalid/rready  out/out/out/in  P_DBYTES*8/2/1/1  AXI4-Lite read-data channel.
REQ-011 SHALL have port amm  amm_if.master  (P_ASIZE, P_DBYTES)  Avalon-MM master: address, writedata, byteenable, write, read out; waitrequest, readdata in.

Function
REQ-012 SHALL implement FSM states IDLE, WR, RD, BRSP, RRSP; one transaction outstanding at a time.
REQ-013 SHALL, in IDLE, treat a write as pending only when awvalid and wvalid are both high; a lone awvalid or wvalid SHALL NOT be accepted.
REQ-014 SHALL, when a write and arvalid are pending in the same IDLE cycle, grant the type not granted last (round-robin); after reset, write wins first.
REQ-015 SHALL, on write grant, pulse awready and wready high together for exactly that cycle, register awaddr, wdata, wstrb, and go to WR.
REQ-016 SHALL, on read grant, pulse arready for exactly that cycle, register araddr, and go to RD.
REQ-017 SHALL drive amm.address = registered address with its low log2(P_DBYTES) bits forced to 0; amm.byteenable = wstrb for writes, all ones for reads.
REQ-018 SHALL assert amm.write (WR) or amm.read (RD) from the cycle after grant, holding address/writedata/byteenable stable until the cycle in which amm.waitrequest is low.
REQ-019 SHALL treat readdata as valid in the cycle read=1 and waitrequest=0 (zero read latency), capturing it into rdata.
REQ-020 SHALL, on completion, deassert read/write the next cycle and enter BRSP (bvalid=1, bresp=2'b00) or RRSP (rvalid=1, rresp=2'b00).
REQ-021 SHALL hold bvalid/rvalid and response fields stable until bready/rready is high, then return to IDLE the next cycle; a ready already high yields a one-cycle valid.
REQ-022 SHALL count consecutive cycles with read/write asserted and waitrequest high; on reaching P_TIMEOUT (nonzero) it SHALL drop the command next cycle and respond with SLVERR (2'b10), rdata = 0.
REQ-023 SHALL clear the timeout counter at every grant.
REQ-024 SHALL give minimum latency: grant cycle N, AMM command in N+1, valid response in N+2 (waitrequest low at N+1).
REQ-025 SHALL never assert amm.read and amm.write in the same cycle.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously force state IDLE; awready, wready, arready, bvalid, rvalid, amm.read, amm.write = 0; bresp, rresp = 2'b00; rdata, amm.address, amm.writedata, amm.byteenable = 0; round-robin pointer = write; timeout counter = 0.
REQ-027 SHALL abandon any in-flight transaction on reset with no response generated; after release, first grant no earlier than the first rising edge with rst_n high.

Verification
REQ-028 SHALL be verified: write awaddr=0x1006, wdata=0xA5A5_0001, wstrb=0x3, waitrequest 2 cycles -> amm.address=0x1004, byteenable=0x3, write held 3 cycles, bresp=OKAY.
REQ-029 SHALL be verified: read araddr=0x20, waitrequest low immediately, readdata=0xDEADBEEF -> rvalid 2 cycles after arready, rdata=0xDEADBEEF, rresp=OKAY.
REQ-030 SHALL be verified: simultaneous write and read after reset, repeated twice -> grant order W, R, W, R.
REQ-031 SHALL be verified: P_TIMEOUT=4, waitrequest stuck high on read -> read deasserts after 4 wait cycles, rresp=2'b10, rdata=0.
REQ-032 SHALL be verified: awvalid without wvalid for 10 cycles, then wvalid -> awready stays 0 until wvalid; bready held low 5 cycles -> bvalid/bresp stable throughout.
REQ-033 SHALL be verified: rst_n asserted mid-WR with waitrequest high -> amm.write=0 immediately, no bvalid after release.
